// File: rtl/phase_sweep.sv
// Receive-phase search controller: settles and measures symbol errors on each of the
// four downsampling phases, then applies and holds the phase with the fewest errors.
module phase_sweep #(
    parameter int unsigned WIN_LOG2 = 10,
    parameter int unsigned SETTLE   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_err_r,
    input  logic                i_err_i,
    output logic [1:0]          o_phase,
    output logic                o_ber_rst,
    output logic                o_busy,
    output logic                o_locked,
    output logic [WIN_LOG2+1:0] o_min_errs
);

    localparam int unsigned EW = WIN_LOG2 + 2;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSettle  = 3'd1;
    localparam logic [2:0] StMeasure = 3'd2;
    localparam logic [2:0] StEval    = 3'd3;
    localparam logic [2:0] StLocked  = 3'd4;

    localparam logic [7:0]          SettleLast = 8'(SETTLE - 1);
    localparam logic [WIN_LOG2-1:0] WinLast    = '1;

    logic [2:0]          state_q, state_d;
    logic [1:0]          phase_idx_q, phase_idx_d;
    logic [1:0]          best_phase_q, best_phase_d;
    logic [EW-1:0]       best_errs_q, best_errs_d;
    logic                final_q, final_d;
    logic [7:0]          set_cnt_q, set_cnt_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [EW-1:0]       err_cnt_q, err_cnt_d;
    logic [1:0]          phase_q, phase_d;
    logic                ber_rst_q, ber_rst_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;
    logic [EW-1:0]       min_errs_q, min_errs_d;
    logic [EW-1:0]       err_tot;

    // Running error count including the current strobe's R and I mismatches.
    always_comb begin
        err_tot = err_cnt_q + EW'(i_err_r) + EW'(i_err_i);
    end

    // Next-state logic for the sweep sequencer and its registered outputs.
    always_comb begin
        state_d      = state_q;
        phase_idx_d  = phase_idx_q;
        best_phase_d = best_phase_q;
        best_errs_d  = best_errs_q;
        final_d      = final_q;
        set_cnt_d    = set_cnt_q;
        win_cnt_d    = win_cnt_q;
        err_cnt_d    = err_cnt_q;
        phase_d      = phase_q;
        ber_rst_d    = ber_rst_q;
        busy_d       = busy_q;
        locked_d     = locked_q;
        min_errs_d   = min_errs_q;

        case (state_q)
            StIdle, StLocked: begin
                if (i_start) begin
                    state_d      = StSettle;
                    phase_idx_d  = 2'd0;
                    phase_d      = 2'd0;
                    best_errs_d  = '1;
                    best_phase_d = 2'd0;
                    final_d      = 1'b0;
                    set_cnt_d    = 8'd0;
                    ber_rst_d    = 1'b0;
                    busy_d       = 1'b1;
                    locked_d     = 1'b0;
                end
            end
            StSettle: begin
                if (i_enable) begin
                    if (set_cnt_q == SettleLast) begin
                        set_cnt_d = 8'd0;
                        err_cnt_d = '0;
                        win_cnt_d = '0;
                        ber_rst_d = 1'b1;
                        if (final_q) begin
                            state_d  = StLocked;
                            busy_d   = 1'b0;
                            locked_d = 1'b1;
                        end else begin
                            state_d = StMeasure;
                        end
                    end else begin
                        set_cnt_d = set_cnt_q + 8'd1;
                    end
                end
            end
            StMeasure: begin
                if (i_enable) begin
                    err_cnt_d = err_tot;
                    win_cnt_d = win_cnt_q + 1'b1;
                    if (win_cnt_q == WinLast) begin
                        // Strict compare: on a tie the earlier (lower) phase wins.
                        if (err_tot < best_errs_q) begin
                            best_errs_d  = err_tot;
                            best_phase_d = phase_idx_q;
                        end
                        // Checkers go back into reset before any phase change.
                        ber_rst_d = 1'b0;
                        set_cnt_d = 8'd0;
                        if (phase_idx_q != 2'd3) begin
                            phase_idx_d = phase_idx_q + 2'd1;
                            phase_d     = phase_idx_q + 2'd1;
                            state_d     = StSettle;
                        end else begin
                            state_d = StEval;
                        end
                    end
                end
            end
            StEval: begin
                phase_d    = best_phase_q;
                min_errs_d = best_errs_q;
                final_d    = 1'b1;
                set_cnt_d  = 8'd0;
                state_d    = StSettle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            phase_idx_q  <= 2'd0;
            best_phase_q <= 2'd0;
            best_errs_q  <= '0;
            final_q      <= 1'b0;
            set_cnt_q    <= 8'd0;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
            phase_q      <= 2'd0;
            ber_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            min_errs_q   <= '0;
        end else begin
            state_q      <= state_d;
            phase_idx_q  <= phase_idx_d;
            best_phase_q <= best_phase_d;
            best_errs_q  <= best_errs_d;
            final_q      <= final_d;
            set_cnt_q    <= set_cnt_d;
            win_cnt_q    <= win_cnt_d;
            err_cnt_q    <= err_cnt_d;
            phase_q      <= phase_d;
            ber_rst_q    <= ber_rst_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            min_errs_q   <= min_errs_d;
        end
    end

    assign o_phase    = phase_q;
    assign o_ber_rst  = ber_rst_q;
    assign o_busy     = busy_q;
    assign o_locked   = locked_q;
    assign o_min_errs = min_errs_q;

endmodule

// File: tb/tb_phase_sweep.sv
// Directed bench for phase_sweep with WIN_LOG2=4, SETTLE=4 and a strobe every 4 clocks.
module tb_phase_sweep;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_start = 1'b0;
    logic       i_err_r = 1'b0;
    logic       i_err_i = 1'b0;
    logic [1:0] o_phase;
    logic       o_ber_rst;
    logic       o_busy;
    logic       o_locked;
    logic [5:0] o_min_errs;

    int vectors = 0;
    int miscompares = 0;

    phase_sweep #(
        .WIN_LOG2(4),
        .SETTLE  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (i_enable),
        .i_start   (i_start),
        .i_err_r   (i_err_r),
        .i_err_i   (i_err_i),
        .o_phase   (o_phase),
        .o_ber_rst (o_ber_rst),
        .o_busy    (o_busy),
        .o_locked  (o_locked),
        .o_min_errs(o_min_errs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic r, input logic i);
        i_enable = 1'b1;
        i_err_r  = r;
        i_err_i  = i;
        tick();
        i_enable = 1'b0;
        i_err_r  = 1'b0;
        i_err_i  = 1'b0;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_ber_rst", 32'(o_ber_rst), 32'd0);
        check("start_locked", 32'(o_locked), 32'd0);
        check("start_phase", 32'(o_phase), 32'd0);
    endtask

    // One complete sweep after start_pulse; er/ei give leading error strobes per phase.
    task automatic sweep(input int er[4], input int ei[4], input bit mid_start,
                         input int exp_phase, input int exp_min);
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 4; s++) begin
                strobe(1'b0, 1'b0);
                if (s == 2) check($sformatf("settle_rst_p%0d", p), 32'(o_ber_rst), 32'd0);
                if (s == 3) begin
                    check($sformatf("measure_rst_p%0d", p), 32'(o_ber_rst), 32'd1);
                    check($sformatf("measure_phase_p%0d", p), 32'(o_phase), 32'(p));
                end
                gap();
            end
            for (int m = 0; m < 16; m++) begin
                strobe(m < er[p], m < ei[p]);
                if (m == 15) begin
                    check($sformatf("end_rst_p%0d", p), 32'(o_ber_rst), 32'd0);
                    check($sformatf("end_phase_p%0d", p), 32'(o_phase),
                          32'(p < 3 ? p + 1 : 3));
                    check($sformatf("end_busy_p%0d", p), 32'(o_busy), 32'd1);
                end
                if (mid_start && p == 1 && m == 8) begin
                    i_start = 1'b1;
                    tick();
                    i_start = 1'b0;
                    check("mid_start_busy", 32'(o_busy), 32'd1);
                    check("mid_start_rst", 32'(o_ber_rst), 32'd1);
                    tick();
                    tick();
                end else begin
                    gap();
                end
            end
        end
        check("eval_phase", 32'(o_phase), 32'(exp_phase));
        check("eval_locked", 32'(o_locked), 32'd0);
        for (int s = 0; s < 4; s++) begin
            strobe(1'b0, 1'b0);
            if (s == 2) check("final_settle_locked", 32'(o_locked), 32'd0);
            gap();
        end
        check("lock_locked", 32'(o_locked), 32'd1);
        check("lock_busy", 32'(o_busy), 32'd0);
        check("lock_ber_rst", 32'(o_ber_rst), 32'd1);
        check("lock_phase", 32'(o_phase), 32'(exp_phase));
        check("lock_min_errs", 32'(o_min_errs), 32'(exp_min));
    endtask

    initial begin
        int zero[4];
        int all[4];
        int e3[4];
        int er4[4];
        zero = '{0, 0, 0, 0};
        all  = '{16, 16, 16, 16};
        e3   = '{16, 16, 0, 16};
        er4  = '{5, 3, 3, 9};

        #12;
        check("rst_phase", 32'(o_phase), 32'd0);
        check("rst_ber_rst", 32'(o_ber_rst), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_locked", 32'(o_locked), 32'd0);
        check("rst_min_errs", 32'(o_min_errs), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        check("idle_busy", 32'(o_busy), 32'd0);

        // Clean channel: lock on phase 0 with zero errors.
        start_pulse();
        sweep(zero, zero, 1'b0, 0, 0);

        // Restart from LOCKED; only phase 2 is clean.
        start_pulse();
        sweep(e3, e3, 1'b0, 2, 0);

        // R-only errors 5,3,3,9: tie between phases 1 and 2 goes to 1; stray start ignored.
        start_pulse();
        sweep(er4, zero, 1'b1, 1, 3);

        // Every strobe errored on both branches: 32 per phase, no overflow.
        start_pulse();
        sweep(all, all, 1'b0, 0, 32);

        // Asynchronous reset during phase-2 MEASURE.
        start_pulse();
        repeat (2 * 20 + 4 + 5) begin
            strobe(1'b1, 1'b0);
            gap();
        end
        check("pre_rst_phase", 32'(o_phase), 32'd2);
        rst = 1'b0;
        #1;
        check("arst_phase", 32'(o_phase), 32'd0);
        check("arst_ber_rst", 32'(o_ber_rst), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_locked", 32'(o_locked), 32'd0);
        check("arst_min_errs", 32'(o_min_errs), 32'd0);
        tick();
        #2;
        rst = 1'b1;
        repeat (10) begin
            strobe(1'b1, 1'b1);
            gap();
        end
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_locked", 32'(o_locked), 32'd0);
        check("post_rst_ber_rst", 32'(o_ber_rst), 32'd0);
        check("post_rst_phase", 32'(o_phase), 32'd0);

        // Recovery sweep after reset.
        start_pulse();
        sweep(zero, zero, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
